hangman_msg_rx: RTL and testbench
=================================

HANGMAN_MSG_RX -- requirements
Module: hangman_msg_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clock cycles per serial bit; even, at least 4; H = CLKS_PER_BIT/2.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-003 SHALL have port nRst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port rx_serial, input, 1: asynchronous serial line from the peer board's message transmitter; idle high.
REQ-005 SHALL have port rx_data, output, 8: last correctly received byte (letter code).
REQ-006 SHALL have port data_ready, output, 1: one-cycle pulse marking rx_data as newly valid.
REQ-007 SHALL have port framing_error, output, 1: stop bit sampled low; held until the next start bit is accepted.
REQ-008 SHALL have port parity_error, output, 1: one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-010 SHALL pass rx_serial through a 2-flop synchronizer; only the synchronized value (rxs) drives the logic.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE, plus a bit counter and a 3-bit data index.
REQ-012 In IDLE, rxs=0 SHALL move to START with counter cleared.
REQ-013 START: at counter=H-1, sample rxs. If 1 (glitch), return to IDLE with no flags and no data_ready. If 0, clear framing_error, clear counter and go to DATA.
REQ-014 DATA: at each counter=CLKS_PER_BIT-1, shift rxs into the shift register LSB-first and clear counter. After the 8th bit, go to PARITY (parity enabled) or STOP.
REQ-015 STOP: at counter=CLKS_PER_BIT-1, sample rxs. If 1 and no parity fault, load rx_data, pulse data_ready for exactly one cycle and go to IDLE. If 0, set framing_error, do not update rx_data, do not pulse data_ready, and go to WAIT_IDLE.
REQ-016 WAIT_IDLE SHALL stay until rxs=1, then go to IDLE; a low line SHALL never be taken as a new start bit while in this state.
REQ-017 Latency: data_ready SHALL rise H+9*CLKS_PER_BIT+2 to H+9*CLKS_PER_BIT+3 cycles after the rx_serial falling edge of the start bit; add CLKS_PER_BIT with parity enabled.
REQ-018 rx_data SHALL change only on the data_ready cycle and hold between frames.
REQ-019 Back-to-back frames (stop bit followed directly by a start bit) SHALL each be received, with no lost byte.
REQ-020 data_ready and parity_error SHALL never both be high in the same cycle.

Reset
REQ-021 nRst low SHALL immediately force: state IDLE, synchronizer flops 1, counter 0, shift register 0, rx_data 8'h00, data_ready 0, framing_error 0, parity_error 0, busy 0.
REQ-022 Reset mid-frame SHALL discard the partial byte; the first falling edge after release starts a fresh frame.

Configuration
REQ-023 Macro HANGMAN_MSG_RX_PARITY_EN defined: the PARITY state samples an even-parity bit at counter=CLKS_PER_BIT-1.
- On mismatch, the frame still completes STOP.
- parity_error pulses one cycle instead of data_ready, and rx_data is unchanged.
- A framing error takes precedence: framing_error set, no parity_error pulse.
REQ-024 Macro undefined: no PARITY state, frame is 10 bits, parity_error tied 0.

Verification (CLKS_PER_BIT=10, parity off unless stated)
REQ-025 Valid frame 0x41 ('A') -> rx_data=0x41, exactly one data_ready pulse within the REQ-017 window, framing_error=0, busy low afterwards.
REQ-026 Frame 0x50 with stop bit low -> framing_error=1, no data_ready, rx_data stays 0x41. Line then held high and frame 0x50 resent -> framing_error=0, rx_data=0x50.
REQ-027 rx_serial low for 3 cycles only (less than H) -> return to IDLE, no data_ready, no framing_error.
REQ-028 nRst asserted during data bit 4 of frame 0x4C -> all outputs at reset values. After release, full frame 0x4C -> rx_data=0x4C, one pulse.
REQ-029 Frames 0x50, 0x50 back-to-back -> two data_ready pulses, 10*CLKS_PER_BIT cycles apart.
REQ-030 Parity on, 0x45 with odd parity bit -> one parity_error pulse, no data_ready. 0x45 with correct parity -> rx_data=0x45, one data_ready pulse.

Source files
------------

// File: rtl/hangman_msg_rx.sv
// Purpose : UART-style byte receiver for letter codes from the peer board (8N1, optional even parity).
// Latency : data_ready rises H+9*CLKS_PER_BIT+2..+3 clocks after the start-bit falling edge (+CLKS_PER_BIT with parity).
// Backpr. : none; the serial line cannot be stalled, so each byte is presented for one cycle on data_ready.
//
// Ports:
//   clk           system clock, rising-edge
//   nRst          asynchronous active-low reset
//   rx_serial     asynchronous serial input, idle high
//   rx_data       last correctly received byte, held between frames
//   data_ready    one-cycle strobe: rx_data newly valid
//   framing_error stop bit sampled low; held until the next start bit is confirmed
//   parity_error  one-cycle strobe on even-parity mismatch (tied 0 without parity)
//   busy          high whenever the receiver is not idle
//
// Build option: define HANGMAN_MSG_RX_PARITY_EN to add an even-parity bit after the data bits.
module hangman_msg_rx #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef HANGMAN_MSG_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
`ifdef HANGMAN_MSG_RX_PARITY_EN
    logic          par_bad;
`endif

    assign busy = (state != IDLE);

`ifndef HANGMAN_MSG_RX_PARITY_EN
    assign parity_error = 1'b0;
`endif

    // Synchronizer resets to the idle level so release never looks like a start bit.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= 3'd0;
            shreg         <= 8'h00;
            rx_data       <= 8'h00;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
`ifdef HANGMAN_MSG_RX_PARITY_EN
            parity_error  <= 1'b0;
            par_bad       <= 1'b0;
`endif
        end else begin
            data_ready   <= 1'b0;
`ifdef HANGMAN_MSG_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= 3'd0;
                    if (!rxs) state <= START;
                end

                // Re-check the line mid-bit so short glitches are dropped silently.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            framing_error <= 1'b0;
                            state         <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Counter was aligned to mid-bit in START, so each full period lands mid-bit.
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef HANGMAN_MSG_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef HANGMAN_MSG_RX_PARITY_EN
                // Even parity: data ones plus parity bit must be even.
                PARITY: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        par_bad <= (rxs != ^shreg);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rxs) begin
`ifdef HANGMAN_MSG_RX_PARITY_EN
                            if (par_bad) begin
                                parity_error <= 1'b1;
                            end else begin
                                rx_data    <= shreg;
                                data_ready <= 1'b1;
                            end
`else
                            rx_data    <= shreg;
                            data_ready <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            // Framing fault wins over any parity fault.
                            framing_error <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Line stuck low after a bad stop bit: wait for idle before hunting again.
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hangman_msg_rx.sv
// Purpose : directed self-checking bench for hangman_msg_rx at CLKS_PER_BIT=10.
// Latency : expected data_ready window 97..98 clocks after start edge (+10 with parity).
// Backpr. : not applicable; stimulus drives the serial line bit by bit.
module tb_hangman_msg_rx;

    localparam int CPB = 10;
`ifdef HANGMAN_MSG_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT_MIN = CPB/2 + 9*CPB + 2 + PAR*CPB;
    localparam int LAT_MAX = LAT_MIN + 1;

    logic       tb_clk = 1'b0;
    logic       nRst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int cyc        = 0;
    int dr_cnt     = 0;
    int pe_cnt     = 0;
    int overlap    = 0;
    int rd_glitch  = 0;
    int last_dr    = 0;
    int prev_dr    = 0;
    int start_cyc  = 0;
    int base;
    logic [7:0] prev_rd = 8'h00;

    hangman_msg_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (tb_clk),
        .nRst          (nRst),
        .rx_serial     (rx_serial),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge tb_clk) begin
        if (data_ready) begin
            dr_cnt++;
            prev_dr = last_dr;
            last_dr = cyc;
        end
        if (parity_error) pe_cnt++;
        if (data_ready && parity_error) overlap++;
        if (nRst && !data_ready && (rx_data !== prev_rd)) rd_glitch++;
        prev_rd = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_serial = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop_v);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR == 1) drive_bit(par_ok ? ^b : ~^b);
        drive_bit(stop_v);
    endtask

    initial begin
        nRst      = 1'b0;
        rx_serial = 1'b1;
        idle(3);
        // Reset state
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_dr", {31'd0, data_ready}, 0);
        check("rst_fe", {31'd0, framing_error}, 0);
        check("rst_pe", {31'd0, parity_error}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        nRst = 1'b1;
        idle(5);

        // Valid frame 'A'
        base = dr_cnt;
        send_frame(8'h41, 1'b1, 1'b1);
        idle(5);
        check("a_data", {24'd0, rx_data}, 32'h41);
        check("a_pulses", dr_cnt - base, 1);
        check("a_lat_win", {31'd0, (last_dr - start_cyc >= LAT_MIN) && (last_dr - start_cyc <= LAT_MAX)}, 1);
        check("a_fe", {31'd0, framing_error}, 0);
        check("a_busy", {31'd0, busy}, 0);

        // Stop bit low, then line held low: must sit in WAIT_IDLE, not restart
        base = dr_cnt;
        send_frame(8'h50, 1'b1, 1'b0);
        idle(30);
        check("fe_set", {31'd0, framing_error}, 1);
        check("fe_wait_busy", {31'd0, busy}, 1);
        rx_serial = 1'b1;
        idle(20);
        check("fe_no_dr", dr_cnt - base, 0);
        check("fe_hold_data", {24'd0, rx_data}, 32'h41);
        check("fe_held", {31'd0, framing_error}, 1);
        check("fe_idle_busy", {31'd0, busy}, 0);
        send_frame(8'h50, 1'b1, 1'b1);
        idle(5);
        check("fe_clear", {31'd0, framing_error}, 0);
        check("resend_data", {24'd0, rx_data}, 32'h50);
        check("resend_pulses", dr_cnt - base, 1);

        // Short glitch
        base = dr_cnt;
        rx_serial = 1'b0;
        idle(3);
        rx_serial = 1'b1;
        idle(20);
        check("gl_no_dr", dr_cnt - base, 0);
        check("gl_fe", {31'd0, framing_error}, 0);
        check("gl_busy", {31'd0, busy}, 0);
        check("gl_data", {24'd0, rx_data}, 32'h50);

        // Reset during data bit 4 of 0x4C
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(bit'((8'h4C >> i) & 8'h01));
        rx_serial = 1'b1;
        idle(4);
        nRst = 1'b0;
        #1;
        check("mr_rx_data", {24'd0, rx_data}, 32'h00);
        check("mr_dr", {31'd0, data_ready}, 0);
        check("mr_fe", {31'd0, framing_error}, 0);
        check("mr_busy", {31'd0, busy}, 0);
        idle(3);
        nRst = 1'b1;
        idle(5);
        base = dr_cnt;
        send_frame(8'h4C, 1'b1, 1'b1);
        idle(5);
        check("mr_data", {24'd0, rx_data}, 32'h4C);
        check("mr_pulses", dr_cnt - base, 1);

        // Back-to-back frames
        base = dr_cnt;
        send_frame(8'h50, 1'b1, 1'b1);
        send_frame(8'h50, 1'b1, 1'b1);
        idle(5);
        check("b2b_pulses", dr_cnt - base, 2);
        check("b2b_spacing", last_dr - prev_dr, (10 + PAR) * CPB);
        check("b2b_data", {24'd0, rx_data}, 32'h50);

`ifdef HANGMAN_MSG_RX_PARITY_EN
        // 0x45 has three ones: wrong parity bit first, then correct one
        base = dr_cnt;
        begin
            int pbase;
            pbase = pe_cnt;
            send_frame(8'h45, 1'b0, 1'b1);
            idle(5);
            check("par_pe_pulse", pe_cnt - pbase, 1);
            check("par_no_dr", dr_cnt - base, 0);
            check("par_hold", {24'd0, rx_data}, 32'h50);
            send_frame(8'h45, 1'b1, 1'b1);
            idle(5);
            check("par_ok_data", {24'd0, rx_data}, 32'h45);
            check("par_ok_dr", dr_cnt - base, 1);
            check("par_ok_pe", pe_cnt - pbase, 1);
        end
`else
        check("pe_never", pe_cnt, 0);
`endif

        check("dr_pe_overlap", overlap, 0);
        check("rx_data_stable", rd_glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
